pwm_fade_seq: RTL and testbench
===============================

// Module: pwm_fade_seq
// PURPOSE
//  Brightness sequencer for the PWM LED core. Generates the core's enable tick from mclk.
//  Steps a duty threshold through RISE -> HOLD -> FALL fade profiles set by latched config.
//  Sits between the control/register logic and the PWM comparator it paces.
// PARAMETERS
//  PRESCALE  100  mclk cycles per tick; legal range >=1
//  WIDTH     8    duty/level width; one frame = 2**WIDTH ticks
//  HOLD_W    8    width of the hold-frame counter
// PORTS
//  mclk        in   1        system clock; all logic on rising edge
//  rst         in   1        synchronous, active-high reset
//  start       in   1        1-cycle request: latch cfg_*, begin a profile
//  stop        in   1        1-cycle abort
//  cfg_peak    in   WIDTH    top level of the ramp
//  cfg_step    in   4        level change per frame; 0 is treated as 1
//  cfg_hold    in   HOLD_W   frames held at peak
//  cfg_repeat  in   1        1 = loop RISE after FALL until stop
//  tick        out  1        1-cycle enable pulse for the PWM core
//  frame       out  1        1-cycle pulse coincident with the last tick of a frame
//  threshold   out  WIDTH    duty threshold to the PWM comparator (registered)
//  busy        out  1        high outside IDLE
//  done        out  1        1-cycle pulse when a non-repeating profile completes
// BEHAVIOUR
//  - Reset: state=IDLE; level, threshold, tick, frame, busy, done = 0; prescaler and frame counters = 0.
//  - Config is latched only on an accepted start. start while busy is ignored.
//  - Accepted start at cycle N: busy=1 at N+1, state=RISE, prescaler and frame counters cleared.
//  - First tick is PRESCALE cycles after start. tick runs only while busy.
//  - frame pulses on the tick where the frame counter wraps from 2**WIDTH-1 to 0.
//  - Level and state change only on frame pulses. threshold updates in the same cycle as level.
//  - RISE: level = min(level+step, peak).
//      On reaching peak: go to HOLD with hold_cnt=cfg_hold, or straight to FALL if cfg_hold==0.
//      cfg_peak==0 reaches peak on the first frame.
//  - HOLD: level unchanged for exactly cfg_hold frames.
//      Each frame: if hold_cnt<=1 go to FALL, else decrement hold_cnt.
//  - FALL: level = max(level-step, 0), saturating with no underflow.
//      On reaching 0: repeat=1 -> RISE. repeat=0 -> IDLE, busy=0 and done=1 in the next cycle.
//  - stop: next cycle state=IDLE, level=threshold=0, busy=0, no done pulse.
//      stop has priority over start in the same cycle.
//      stop while IDLE has no effect.
//  - Arithmetic is done in WIDTH+1 bits, then saturated, so there is no wrap-around.
//  - rst mid-profile behaves exactly like the reset state. No done pulse.
// CONFIGURATION
//  PWM_FADE_GAMMA_EN defined:
//      threshold = (level*level) >> WIDTH, loaded in the same cycle as level.
//      Gives perceptual (gamma ~2) fading.
//  PWM_FADE_GAMMA_EN not defined:
//      threshold = level, linear.
//  State sequence and timing are identical in both cases.
// STRUCTURE
//  - Package pwm_fade_pkg: state enum (IDLE, RISE, HOLD, FALL), STEP_W=4, saturating add/sub functions.
//  - Sub-module pwm_tick_gen(mclk, rst, en, clr -> tick).
//      Modulo-PRESCALE counter. en=busy, clr=accepted start.
//  - Top holds the FSM, frame counter, hold counter, level/threshold registers and the gamma path.
// TESTING (bench uses PRESCALE=2, WIDTH=4; frame = 16 ticks = 32 cycles)
//  1. rst high for 3 cycles -> all outputs 0, no tick; after release with no start, tick stays 0 for 100 cycles.
//  2. start, peak=8, step=4, hold=1, repeat=0 -> threshold per frame 4, 8, 8, 4, 0.
//     done pulses once, one cycle after the 5th frame pulse; busy falls in the same cycle.
//  3. peak=10, step=0, hold=0 -> step used as 1; threshold rises 1..10, then goes straight to FALL 9..0.
//     There is no hold frame at 10.
//  4. repeat=1, peak=4, step=4, hold=0 -> threshold 4, 0, 4, 0... with no done.
//     stop asserted together with start mid-FALL -> next cycle threshold=0, busy=0, no done.
//  5. start asserted while busy, with different cfg -> ignored; profile completes with the original cfg.
//     rst asserted in HOLD -> reset values next cycle.
//  6. PWM_FADE_GAMMA_EN defined, WIDTH=8, peak=255, step=15:
//     level 128 -> threshold 64; level 255 -> threshold 254; level 15 -> threshold 0.

Source files
------------

// File: rtl/pwm_fade_pkg.sv
// Shared types and saturating helpers for the PWM fade sequencer.
package pwm_fade_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RISE = 2'd1,
      HOLD = 2'd2,
      FALL = 2'd3
   } state_e;

   localparam int STEP_W = 4;
   // Wide enough for WIDTH+1 bit arithmetic with WIDTH up to 16.
   localparam int SAT_W  = 17;

   typedef logic [SAT_W-1:0] sat_t;

   function automatic sat_t sat_add(input sat_t a, input sat_t b, input sat_t limit);
      sat_t s;
      s = a + b;
      return (s > limit) ? limit : s;
   endfunction

   function automatic sat_t sat_sub(input sat_t a, input sat_t b);
      return (a > b) ? (a - b) : '0;
   endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Modulo-PRESCALE enable generator; tick fires on the last count of each period.
module pwm_tick_gen #(
   parameter int PRESCALE = 100
) (
   input  logic mclk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr || !en) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge mclk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/pwm_fade_seq.sv
// Fade sequencer: RISE -> HOLD -> FALL brightness profiles paced by frame pulses.
// Define PWM_FADE_GAMMA_EN to drive threshold = level^2 >> WIDTH instead of level.
module pwm_fade_seq
   import pwm_fade_pkg::*;
#(
   parameter int PRESCALE = 100,
   parameter int WIDTH    = 8,
   parameter int HOLD_W   = 8
) (
   input  logic              mclk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic [WIDTH-1:0]  cfg_peak,
   input  logic [STEP_W-1:0] cfg_step,
   input  logic [HOLD_W-1:0] cfg_hold,
   input  logic              cfg_repeat,
   output logic              tick,
   output logic              frame,
   output logic [WIDTH-1:0]  threshold,
   output logic              busy,
   output logic              done
);

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  level_q, level_d;
   logic [WIDTH-1:0]  thr_q, thr_d;
   logic [WIDTH-1:0]  fcnt_q, fcnt_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [WIDTH-1:0]  peak_q;
   logic [STEP_W-1:0] step_q;
   logic [HOLD_W-1:0] hold_cfg_q;
   logic              rep_q;
   logic              done_q, done_d;
   logic              busy_w, accept, abort;
   sat_t              rise_sum, fall_dif;

   assign busy_w = (state_q != IDLE);
   assign accept = start && !busy_w && !stop;
   assign abort  = stop && busy_w;

   pwm_tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
      .mclk (mclk),
      .rst  (rst),
      .en   (busy_w),
      .clr  (accept),
      .tick (tick)
   );

   assign frame  = tick && (fcnt_q == {WIDTH{1'b1}});
   assign fcnt_d = !busy_w ? '0 : (tick ? fcnt_q + 1'b1 : fcnt_q);

   always_ff @(posedge mclk) begin
      if (rst) begin
         peak_q     <= '0;
         step_q     <= STEP_W'(1);
         hold_cfg_q <= '0;
         rep_q      <= 1'b0;
      end else if (accept) begin
         peak_q     <= cfg_peak;
         step_q     <= (cfg_step == '0) ? STEP_W'(1) : cfg_step;
         hold_cfg_q <= cfg_hold;
         rep_q      <= cfg_repeat;
      end
   end

   always_ff @(posedge mclk) begin
      if (rst) begin
         state_q <= IDLE;
         level_q <= '0;
         thr_q   <= '0;
         fcnt_q  <= '0;
         hold_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         thr_q   <= thr_d;
         fcnt_q  <= fcnt_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
      end
   end

   assign rise_sum = sat_add(sat_t'(level_q), sat_t'(step_q), sat_t'(peak_q));
   assign fall_dif = sat_sub(sat_t'(level_q), sat_t'(step_q));

   always_comb begin
      state_d = state_q;
      level_d = level_q;
      hold_d  = hold_q;
      if (abort) begin
         state_d = IDLE;
         level_d = '0;
      end else if (accept) begin
         state_d = RISE;
      end else if (frame) begin
         unique case (state_q)
            RISE: begin
               level_d = WIDTH'(rise_sum);
               if (rise_sum == sat_t'(peak_q)) begin
                  state_d = (hold_cfg_q == '0) ? FALL : HOLD;
                  hold_d  = hold_cfg_q;
               end
            end
            HOLD: begin
               if (hold_q <= HOLD_W'(1)) begin
                  state_d = FALL;
               end else begin
                  hold_d = hold_q - 1'b1;
               end
            end
            FALL: begin
               level_d = WIDTH'(fall_dif);
               if (fall_dif == '0) begin
                  state_d = rep_q ? RISE : IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      busy   = busy_w;
      done_d = (state_q == FALL) && (state_d == IDLE) && !abort;
   end

`ifdef PWM_FADE_GAMMA_EN
   logic [2*WIDTH-1:0] level_sq;
   always_comb begin
      level_sq = (2*WIDTH)'(level_d) * (2*WIDTH)'(level_d);
      thr_d    = WIDTH'(level_sq >> WIDTH);
   end
`else
   always_comb begin
      thr_d = level_d;
   end
`endif

   assign threshold = thr_q;
   assign done      = done_q;

endmodule

// File: tb/tb_pwm_fade_seq.sv
// Directed bench for pwm_fade_seq with PRESCALE=2, WIDTH=4 (one frame = 32 mclk cycles).
module tb_pwm_fade_seq;

   localparam int P  = 2;
   localparam int W  = 4;
   localparam int HW = 8;

   logic          mclk = 1'b0;
   logic          rst, start, stop, cfg_repeat;
   logic [W-1:0]  cfg_peak;
   logic [3:0]    cfg_step;
   logic [HW-1:0] cfg_hold;
   logic          tick, frame, busy, done;
   logic [W-1:0]  threshold;

   int errors = 0;
   int checks = 0;

   always #5 mclk = ~mclk;

   pwm_fade_seq #(.PRESCALE(P), .WIDTH(W), .HOLD_W(HW)) u_dut (
      .mclk       (mclk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .cfg_peak   (cfg_peak),
      .cfg_step   (cfg_step),
      .cfg_hold   (cfg_hold),
      .cfg_repeat (cfg_repeat),
      .tick       (tick),
      .frame      (frame),
      .threshold  (threshold),
      .busy       (busy),
      .done       (done)
   );

`ifdef PWM_FADE_GAMMA_EN
   logic       g_start = 1'b0, g_stop = 1'b0;
   logic [7:0] g_peak = '0, g_thr;
   logic [3:0] g_step = '0;
   logic [7:0] g_hold = '0;
   logic       g_tick, g_frame, g_busy, g_done;

   pwm_fade_seq #(.PRESCALE(1), .WIDTH(8), .HOLD_W(8)) u_dut_g (
      .mclk       (mclk),
      .rst        (rst),
      .start      (g_start),
      .stop       (g_stop),
      .cfg_peak   (g_peak),
      .cfg_step   (g_step),
      .cfg_hold   (g_hold),
      .cfg_repeat (1'b0),
      .tick       (g_tick),
      .frame      (g_frame),
      .threshold  (g_thr),
      .busy       (g_busy),
      .done       (g_done)
   );
`endif

   function automatic int eth(input int l);
`ifdef PWM_FADE_GAMMA_EN
      return (l * l) >> W;
`else
      return l;
`endif
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge mclk);
         #1;
      end
   endtask

   // Returns in the cycle after a frame pulse, where threshold/done reflect it.
   task automatic wait_frame(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (frame === 1'b1) begin
            ok = 1'b1;
            break;
         end
         cyc(1);
      end
      if (ok) cyc(1);
   endtask

   task automatic do_start(input int peak, input int step, input int hold, input bit rep);
      cfg_peak   = W'(peak);
      cfg_step   = 4'(step);
      cfg_hold   = HW'(hold);
      cfg_repeat = rep;
      start      = 1'b1;
      cyc(1);
      start      = 1'b0;
   endtask

   task automatic test_reset;
      int n;
      rst = 1'b1; start = 1'b0; stop = 1'b0;
      cfg_peak = '0; cfg_step = '0; cfg_hold = '0; cfg_repeat = 1'b0;
      cyc(3);
      checks++; if (threshold !== '0) begin errors++; $display("FAIL reset_thr got=%0d want=0", threshold); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b want=0", tick); end
      checks++; if (frame !== 1'b0) begin errors++; $display("FAIL reset_frame got=%b want=0", frame); end
      rst = 1'b0;
      n = 0;
      repeat (100) begin
         cyc(1);
         if (tick !== 1'b0) n++;
      end
      checks++; if (n != 0) begin errors++; $display("FAIL idle_ticks got=%0d want=0", n); end
   endtask

   task automatic test_basic_profile;
      int exp_l[5] = '{4, 8, 8, 4, 0};
      bit ok;
      do_start(8, 4, 1, 1'b0);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got=%b want=1", busy); end
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL tick_early got=%b want=0", tick); end
      cyc(1);
      checks++; if (tick !== 1'b1) begin errors++; $display("FAIL first_tick got=%b want=1", tick); end
      for (int i = 0; i < 5; i++) begin
         wait_frame(ok);
         checks++; if (!ok) begin errors++; $display("FAIL basic_frame%0d got=timeout want=frame", i); end
         checks++; if (threshold !== W'(eth(exp_l[i]))) begin errors++; $display("FAIL basic_thr%0d got=%0d want=%0d", i, threshold, eth(exp_l[i])); end
         checks++; if (done !== (i == 4)) begin errors++; $display("FAIL basic_done%0d got=%b want=%b", i, done, i == 4); end
         checks++; if (busy !== (i != 4)) begin errors++; $display("FAIL basic_busy%0d got=%b want=%b", i, busy, i != 4); end
      end
      cyc(1);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_width got=%b want=0", done); end
   endtask

   task automatic test_step_zero;
      bit ok;
      int e;
      do_start(10, 0, 0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         e = (i < 10) ? i + 1 : 19 - i;
         wait_frame(ok);
         checks++; if (!ok) begin errors++; $display("FAIL step0_frame%0d got=timeout want=frame", i); end
         checks++; if (threshold !== W'(eth(e))) begin errors++; $display("FAIL step0_thr%0d got=%0d want=%0d", i, threshold, eth(e)); end
      end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL step0_done got=%b want=1", done); end
   endtask

   task automatic test_repeat_stop;
      bit ok;
      int n;
      do_start(4, 4, 0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         wait_frame(ok);
         checks++; if (!ok) begin errors++; $display("FAIL rep_frame%0d got=timeout want=frame", i); end
         checks++; if (threshold !== W'(eth((i % 2 == 0) ? 4 : 0))) begin errors++; $display("FAIL rep_thr%0d got=%0d want=%0d", i, threshold, eth((i % 2 == 0) ? 4 : 0)); end
         checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rep_state%0d got=done%b/busy%b want=done0/busy1", i, done, busy); end
      end
      cyc(10);
      cfg_peak = 4'd15; cfg_step = 4'd1;
      stop = 1'b1; start = 1'b1;
      cyc(1);
      stop = 1'b0; start = 1'b0;
      checks++; if (threshold !== '0) begin errors++; $display("FAIL stop_thr got=%0d want=0", threshold); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy got=%b want=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL stop_done got=%b want=0", done); end
      n = 0;
      repeat (40) begin
         cyc(1);
         if (done !== 1'b0 || tick !== 1'b0 || busy !== 1'b0) n++;
      end
      checks++; if (n != 0) begin errors++; $display("FAIL stop_quiet got=%0d want=0", n); end
   endtask

   task automatic test_busy_start_and_rst;
      int exp_l[5] = '{4, 8, 8, 4, 0};
      bit ok;
      int n;
      do_start(8, 4, 1, 1'b0);
      cyc(3);
      cfg_peak = 4'd15; cfg_step = 4'd1; cfg_hold = 8'd0; cfg_repeat = 1'b1;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wait_frame(ok);
         checks++; if (!ok) begin errors++; $display("FAIL ign_frame%0d got=timeout want=frame", i); end
         checks++; if (threshold !== W'(eth(exp_l[i]))) begin errors++; $display("FAIL ign_thr%0d got=%0d want=%0d", i, threshold, eth(exp_l[i])); end
      end
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ign_end got=done%b/busy%b want=done1/busy0", done, busy); end
      cyc(2);
      do_start(4, 4, 3, 1'b0);
      wait_frame(ok);
      checks++; if (!ok || threshold !== W'(eth(4))) begin errors++; $display("FAIL hold_entry got=%0d want=%0d", threshold, eth(4)); end
      wait_frame(ok);
      checks++; if (!ok || threshold !== W'(eth(4)) || busy !== 1'b1) begin errors++; $display("FAIL hold_frame got=%0d/busy%b want=%0d/busy1", threshold, busy, eth(4)); end
      cyc(5);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      checks++; if (threshold !== '0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid got=%0d/busy%b want=0/busy0", threshold, busy); end
      checks++; if (done !== 1'b0 || tick !== 1'b0 || frame !== 1'b0) begin errors++; $display("FAIL rst_pulses got=done%b/tick%b/frame%b want=000", done, tick, frame); end
      n = 0;
      repeat (100) begin
         cyc(1);
         if (done !== 1'b0 || tick !== 1'b0) n++;
      end
      checks++; if (n != 0) begin errors++; $display("FAIL rst_quiet got=%0d want=0", n); end
   endtask

`ifdef PWM_FADE_GAMMA_EN
   task automatic wait_gframe(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (g_frame === 1'b1) begin
            ok = 1'b1;
            break;
         end
         cyc(1);
      end
      if (ok) cyc(1);
   endtask

   task automatic test_gamma;
      bit ok;
      g_peak = 8'd128; g_step = 4'd15; g_start = 1'b1;
      cyc(1);
      g_start = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         wait_gframe(ok);
         checks++; if (!ok) begin errors++; $display("FAIL g_frame%0d got=timeout want=frame", k); end
         if (k == 1) begin
            checks++; if (g_thr !== 8'd0) begin errors++; $display("FAIL gamma_15 got=%0d want=0", g_thr); end
         end
         if (k == 9) begin
            checks++; if (g_thr !== 8'd64) begin errors++; $display("FAIL gamma_128 got=%0d want=64", g_thr); end
         end
      end
      g_stop = 1'b1;
      cyc(1);
      g_stop = 1'b0;
      g_peak = 8'd255; g_start = 1'b1;
      cyc(1);
      g_start = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         wait_gframe(ok);
         checks++; if (!ok) begin errors++; $display("FAIL g2_frame%0d got=timeout want=frame", k); end
      end
      checks++; if (g_thr !== 8'd254) begin errors++; $display("FAIL gamma_255 got=%0d want=254", g_thr); end
      g_stop = 1'b1;
      cyc(1);
      g_stop = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_basic_profile();
      test_step_zero();
      test_repeat_stop();
      test_busy_start_and_rst();
`ifdef PWM_FADE_GAMMA_EN
      test_gamma();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
